block_aligner: RTL
==================

// Module: block_aligner
// PURPOSE
//  64b/67b block-lock controller; closes the word-alignment loop around stream_manipulator.
//  Consumes its aligned DATA_OUT and checks the 2-bit Interlaken sync header.
//  Drives its OFFSET, slipping one bit per failed header, until lock is acquired and then held.
//  Sits between the GT RX datapath and the descrambler / framing-layer stages.
// PARAMETERS
//  DATA_WIDTH     80  width of aligned word bus from stream_manipulator
//  HDR_MSB        66  bit index of sync header MSB; header = DATA_IN[HDR_MSB:HDR_MSB-1]
//  OFFSET_MAX     63  highest OFFSET before wrap to 0; must be <= 63
//  LOCK_CNT       64  consecutive valid headers required to declare lock
//  WIN_LEN        64  monitoring window length (valid words) while locked
//  ERR_THRESH     16  header errors within one window that force loss of lock
//  SLIP_WAIT_CYC   2  USER_CLK cycles discarded after each slip (pipeline latency)
// PORTS
//  USER_CLK       in   1           system clock, all logic posedge
//  RESET          in   1           synchronous, active-high reset
//  DATA_IN        in   DATA_WIDTH  aligned word (stream_manipulator DATA_OUT)
//  DATA_VALID     in   1           DATA_IN carries a word this cycle (gearbox gaps)
//  OFFSET         out  6           registered bit offset to stream_manipulator
//  BLOCK_LOCK     out  1           registered; 1 = word boundary locked
//  LOCK_LOST      out  1           one-cycle pulse on LOCKED->unlocked transition
//  SLIP_COUNT     out  16          saturating count of slips since reset
// BEHAVIOUR
//  Reset: OFFSET=0, BLOCK_LOCK=0, LOCK_LOST=0, SLIP_COUNT=0, state=TEST, all counters 0.
//  Header valid <=> DATA_IN[HDR_MSB] != DATA_IN[HDR_MSB-1] (01 or 10). 00/11 = error.
//  Words are evaluated only when DATA_VALID=1. Otherwise sh_cnt, err_cnt and win_cnt hold.
//  States:
//   TEST: valid hdr -> sh_cnt++; when sh_cnt reaches LOCK_CNT -> LOCKED, BLOCK_LOCK=1 same edge.
//         bad hdr -> SLIP.
//   SLIP (single-edge action, from TEST or LOCKED):
//         OFFSET <= (OFFSET==OFFSET_MAX) ? 0 : OFFSET+1; SLIP_COUNT++ (sat at 0xFFFF);
//         sh_cnt, err_cnt, win_cnt <= 0; wait_cnt <= SLIP_WAIT_CYC; -> WAIT.
//   WAIT: wait_cnt-- every cycle, independent of DATA_VALID; all headers ignored; 0 -> TEST.
//   LOCKED: per valid word, win_cnt++; bad hdr -> err_cnt++.
//         err_cnt reaching ERR_THRESH -> BLOCK_LOCK=0, LOCK_LOST=1 for 1 cycle, SLIP.
//         win_cnt reaching WIN_LEN with err_cnt < ERR_THRESH -> win_cnt, err_cnt <= 0; stay.
//         If the last word of a window is the ERR_THRESH-th error, unlock wins over window reset.
//  Latency:
//   OFFSET change appears on DATA_IN SLIP_WAIT_CYC edges later. WAIT covers exactly that.
//   BLOCK_LOCK rises on the edge that samples the LOCK_CNT-th good header.
//  Counter widths: ceil(log2(X+1)) of their limits; no wrap in normal operation.
//  RESET asserted in any state (incl. WAIT or LOCKED): next edge returns to reset values.
//   No LOCK_LOST pulse is generated by reset.
//  DATA_VALID=0 for the whole of WAIT is legal; WAIT still exits on cycle count.
// STRUCTURE
//  Shared header interlaken_defs.vh:
//   - state encodings (TEST, WAIT, LOCKED; SLIP is a transition action, not a state);
//   - default LOCK_CNT/WIN_LEN/ERR_THRESH constants;
//   - sync-header codes 2'b01 (data) and 2'b10 (control).
//  Single flat module; no sub-module needed (FSM + 4 counters + offset register).
// TESTING
//  1 Reset; feed valid headers aligned at true offset 5, garbage elsewhere
//    -> 5 slips, OFFSET=5, SLIP_COUNT=5.
//    BLOCK_LOCK=1 on the 64th good word after the last WAIT.
//  2 Locked; inject 15 bad hdrs in one 64-word window
//    -> BLOCK_LOCK stays 1; counters clear at window end.
//    Inject 16 -> BLOCK_LOCK=0, LOCK_LOST pulse, OFFSET+1.
//  3 OFFSET=63 and bad hdr in TEST -> OFFSET=0 next edge, SLIP_COUNT+1.
//  4 Bad hdrs during both WAIT cycles -> ignored; no extra slip; TEST resumes on cycle 3.
//  5 Toggle DATA_VALID 50% while acquiring
//    -> lock after exactly 64 valid good words; invalid cycles not counted.
//  6 Assert RESET for 1 cycle while LOCKED -> OFFSET=0, BLOCK_LOCK=0, SLIP_COUNT=0, no LOCK_LOST.

Source files
------------

// File: rtl/block_aligner_pkg.sv
// rtl/block_aligner_pkg.sv - shared states, defaults and sync-header helpers for block_aligner
package block_aligner_pkg;

    // SLIP is a single-edge action taken on the way into ST_WAIT, not a state.
    typedef enum logic [1:0] {
        ST_TEST   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int DEF_LOCK_CNT   = 64;
    localparam int DEF_WIN_LEN    = 64;
    localparam int DEF_ERR_THRESH = 16;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    function automatic logic hdr_valid(input logic [1:0] hdr);
        return (hdr == SH_DATA) || (hdr == SH_CTRL);
    endfunction

endpackage

// File: rtl/block_aligner.sv
// rtl/block_aligner.sv - 64b/67b sync-header block-lock FSM driving the word-alignment offset
module block_aligner
    import block_aligner_pkg::*;
#(
    parameter int DATA_WIDTH    = 80,
    parameter int HDR_MSB       = 66,
    parameter int OFFSET_MAX    = 63,
    parameter int LOCK_CNT      = DEF_LOCK_CNT,
    parameter int WIN_LEN       = DEF_WIN_LEN,
    parameter int ERR_THRESH    = DEF_ERR_THRESH,
    parameter int SLIP_WAIT_CYC = 2
) (
    input  logic                  USER_CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  DATA_VALID,
    output logic [5:0]            OFFSET,
    output logic                  BLOCK_LOCK,
    output logic                  LOCK_LOST,
    output logic [15:0]           SLIP_COUNT
);

    localparam int SH_W   = $clog2(LOCK_CNT + 1);
    localparam int ERR_W  = $clog2(ERR_THRESH + 1);
    localparam int WIN_W  = $clog2(WIN_LEN + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT_CYC + 1);

    localparam logic [SH_W-1:0]   SH_LAST    = SH_W'(LOCK_CNT - 1);
    localparam logic [ERR_W-1:0]  ERR_LIMIT  = ERR_W'(ERR_THRESH);
    localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(WIN_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(SLIP_WAIT_CYC);
    localparam logic [5:0]        OFF_LIMIT  = 6'(OFFSET_MAX);

    state_e            state_q, state_d;
    logic [5:0]        offset_q, offset_d;
    logic [15:0]       slip_cnt_q, slip_cnt_d;
    logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              block_lock_q, block_lock_d;
    logic              lock_lost_q, lock_lost_d;

    logic              hdr_ok;
    logic              do_slip;
    logic [ERR_W-1:0]  err_next;
    logic              unused_data;

    assign hdr_ok      = hdr_valid(DATA_IN[HDR_MSB -: 2]);
    assign err_next    = err_cnt_q + {{(ERR_W-1){1'b0}}, ~hdr_ok};
    assign unused_data = ^DATA_IN;

    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        slip_cnt_d   = slip_cnt_q;
        sh_cnt_d     = sh_cnt_q;
        err_cnt_d    = err_cnt_q;
        win_cnt_d    = win_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        block_lock_d = block_lock_q;
        lock_lost_d  = 1'b0;
        do_slip      = 1'b0;

        case (state_q)
            ST_TEST: begin
                if (DATA_VALID) begin
                    if (!hdr_ok) begin
                        do_slip = 1'b1;
                    end else if (sh_cnt_q == SH_LAST) begin
                        state_d      = ST_LOCKED;
                        block_lock_d = 1'b1;
                        sh_cnt_d     = '0;
                        err_cnt_d    = '0;
                        win_cnt_d    = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + 1'b1;
                    end
                end
            end
            // Headers are ignored here: DATA_IN still reflects the pre-slip offset.
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (wait_cnt_q <= WAIT_W'(1)) begin
                    state_d = ST_TEST;
                end
            end
            ST_LOCKED: begin
                if (DATA_VALID) begin
                    if (err_next == ERR_LIMIT) begin
                        block_lock_d = 1'b0;
                        lock_lost_d  = 1'b1;
                        do_slip      = 1'b1;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        err_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        err_cnt_d = err_next;
                    end
                end
            end
            default: begin
                state_d = ST_TEST;
            end
        endcase

        if (do_slip) begin
            offset_d   = (offset_q == OFF_LIMIT) ? 6'd0 : offset_q + 6'd1;
            slip_cnt_d = (slip_cnt_q == 16'hFFFF) ? slip_cnt_q : slip_cnt_q + 16'd1;
            sh_cnt_d   = '0;
            err_cnt_d  = '0;
            win_cnt_d  = '0;
            wait_cnt_d = WAIT_LOAD;
            state_d    = ST_WAIT;
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            state_q      <= ST_TEST;
            offset_q     <= '0;
            slip_cnt_q   <= '0;
            sh_cnt_q     <= '0;
            err_cnt_q    <= '0;
            win_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            block_lock_q <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            slip_cnt_q   <= slip_cnt_d;
            sh_cnt_q     <= sh_cnt_d;
            err_cnt_q    <= err_cnt_d;
            win_cnt_q    <= win_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            block_lock_q <= block_lock_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    assign OFFSET     = offset_q;
    assign BLOCK_LOCK = block_lock_q;
    assign LOCK_LOST  = lock_lost_q;
    assign SLIP_COUNT = slip_cnt_q;

endmodule
